regfile_debug_arbiter: RTL

- Sequences the decode-stage register file between the pipeline and an external debug port.
- On a debug halt it stalls fetch and decode and flushes the E stage. It then waits for in-flight instructions to write back, hands the register file ports to the debugger, and resumes the pipeline on release.
- Sits between the pipeline (RS1D/RS2D, W-stage write) and the register_file instance in decode.

---
 rtl/regfile_debug_arbiter_pkg.sv | 17 +
 rtl/regfile_debug_arbiter_port_mux.sv | 48 ++++
 rtl/regfile_debug_arbiter.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/regfile_debug_arbiter_pkg.sv
// Shared definitions for the decode-stage register file debug arbiter.
//   - arb_state_t : arbiter FSM state encoding
//   - XLEN_DEF / AW_DEF / DRAIN_CYCLES_DEF : default widths and drain length
package regfile_debug_arbiter_pkg;

  localparam int XLEN_DEF         = 32;
  localparam int AW_DEF           = 5;
  localparam int DRAIN_CYCLES_DEF = 3;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_ACCESS = 2'd3
  } arb_state_t;

endpackage

// File: rtl/regfile_debug_arbiter_port_mux.sv
// Combinational owner select for the register file ports.
// Ports:
//   sel_dbg                       : 1 = debugger owns read/write addressing
//   dbg_wr_en                     : qualified debug write strobe (ACCESS, we, addr != 0)
//   rs1d/rs2d/rdw/reg_write_w/result_w : pipeline side
//   dbg_addr/dbg_wdata            : debug side
//   a1/a2/a3/we3/wd3              : register file ports
module regfile_debug_arbiter_port_mux
  import regfile_debug_arbiter_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic            sel_dbg,
  input  logic            dbg_wr_en,
  input  logic [AW-1:0]   rs1d,
  input  logic [AW-1:0]   rs2d,
  input  logic [AW-1:0]   rdw,
  input  logic            reg_write_w,
  input  logic [XLEN-1:0] result_w,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic [AW-1:0]   a1,
  output logic [AW-1:0]   a2,
  output logic [AW-1:0]   a3,
  output logic            we3,
  output logic [XLEN-1:0] wd3
);

  always_comb begin
    if (sel_dbg) begin
      // Debugger owns the file: port 2 is parked on x0, writes only
      // happen on the qualified strobe.
      a1  = dbg_addr;
      a2  = '0;
      a3  = dbg_addr;
      we3 = dbg_wr_en;
      wd3 = dbg_wdata;
    end else begin
      a1  = rs1d;
      a2  = rs2d;
      a3  = rdw;
      we3 = reg_write_w;
      wd3 = result_w;
    end
  end

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Sequences the decode-stage register file between the pipeline and a
// debug port. On dbg_halt, fetch/decode stall and E is flushed; after
// DRAIN_CYCLES the in-flight instructions have written back and the
// debugger gets the register file. Each debug access takes one ACCESS
// cycle followed by a one-cycle dbg_ack pulse.
// Handshake: dbg_req is honoured only in HALTED while dbg_ack is low; the
// debugger holds req and its fields stable until dbg_ack and drops req in
// the ack cycle. dbg_rdata is valid with dbg_ack.
// Ports:
//   clk, rst (sync, active high)
//   RS1D/RS2D/RegWriteW/RDW/ResultW : pipeline register file requests
//   RD1                             : register file read data 1
//   A1/A2/A3/WE3/WD3                : register file ports
//   StallF/StallD/FlushE            : pipeline hazard controls
//   dbg_halt/dbg_halted/dbg_req/dbg_we/dbg_addr/dbg_wdata/dbg_ack/dbg_rdata
module regfile_debug_arbiter
  import regfile_debug_arbiter_pkg::*;
#(
  parameter int XLEN         = XLEN_DEF,
  parameter int AW           = AW_DEF,
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   RS1D,
  input  logic [AW-1:0]   RS2D,
  input  logic            RegWriteW,
  input  logic [AW-1:0]   RDW,
  input  logic [XLEN-1:0] ResultW,
  input  logic [XLEN-1:0] RD1,
  output logic [AW-1:0]   A1,
  output logic [AW-1:0]   A2,
  output logic [AW-1:0]   A3,
  output logic            WE3,
  output logic [XLEN-1:0] WD3,
  output logic            StallF,
  output logic            StallD,
  output logic            FlushE,
  input  logic            dbg_halt,
  output logic            dbg_halted,
  input  logic            dbg_req,
  input  logic            dbg_we,
  input  logic [AW-1:0]   dbg_addr,
  input  logic [XLEN-1:0] dbg_wdata,
  output logic            dbg_ack,
  output logic [XLEN-1:0] dbg_rdata
);

  localparam int CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  arb_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            ack_q, ack_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic addr_is_x0;
  assign addr_is_x0 = (dbg_addr == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    rdata_d = rdata_q;
    case (state_q)
      ST_RUN: begin
        if (dbg_halt) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end
      end
      ST_DRAIN: begin
        // Halt release here is deliberately ignored; HALTED resolves it.
        if (cnt_q == CNT_LAST) begin
          state_d = ST_HALTED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HALTED: begin
        // A req still high in the ack cycle is the previous access.
        // A new req beats a simultaneous halt release.
        if (dbg_req && !ack_q) begin
          state_d = ST_ACCESS;
        end else if (!dbg_halt) begin
          state_d = ST_RUN;
        end
      end
      ST_ACCESS: begin
        state_d = ST_HALTED;
        ack_d   = 1'b1;
        // RD1 is the asynchronous read, so this captures the pre-write value.
        rdata_d = addr_is_x0 ? '0 : RD1;
      end
      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Moore outputs decoded from state.
  logic stall_all;
  logic sel_dbg;
  logic dbg_wr_en;
  assign stall_all  = (state_q != ST_RUN);
  assign sel_dbg    = (state_q == ST_HALTED) || (state_q == ST_ACCESS);
  assign dbg_wr_en  = (state_q == ST_ACCESS) && dbg_we && !addr_is_x0;

  assign StallF     = stall_all;
  assign StallD     = stall_all;
  assign FlushE     = stall_all;
  assign dbg_halted = sel_dbg;
  assign dbg_ack    = ack_q;
  assign dbg_rdata  = rdata_q;

  regfile_debug_arbiter_port_mux #(
    .XLEN(XLEN),
    .AW  (AW)
  ) u_port_mux (
    .sel_dbg    (sel_dbg),
    .dbg_wr_en  (dbg_wr_en),
    .rs1d       (RS1D),
    .rs2d       (RS2D),
    .rdw        (RDW),
    .reg_write_w(RegWriteW),
    .result_w   (ResultW),
    .dbg_addr   (dbg_addr),
    .dbg_wdata  (dbg_wdata),
    .a1         (A1),
    .a2         (A2),
    .a3         (A3),
    .we3        (WE3),
    .wd3        (WD3)
  );

endmodule
